// File: rtl/axi_pkg.sv
// Shared definitions for the AXI4 burst write master: FSM encoding, AXI constants
// and the transfer-size helper.
package axi_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StAddr = 3'd1;
  localparam state_t StData = 3'd2;
  localparam state_t StResp = 3'd3;
  localparam state_t StFin  = 3'd4;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int unsigned BOUNDARY_4K = 4096;

  // AxSIZE encoding for a full-width beat; only 32 and 64 bit buses are supported.
  function automatic logic [2:0] axi_size(input int unsigned dw);
    return (dw == 64) ? 3'd3 : 3'd2;
  endfunction

endpackage

// File: rtl/axi_burst_len_calc.sv
// Beat count of the next INCR burst: the smallest of the burst cap, the beats still
// owed and the beats left before the next 4 KB boundary.
module axi_burst_len_calc
  import axi_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic [11:0]      addr_lo,
  input  logic [CNT_W-1:0] remaining,
  output logic [8:0]       len
);

  localparam int unsigned BeatShift = $clog2(DW / 8);

  logic [12:0] bytes_to_bound;
  logic [31:0] beats_to_bound;
  logic [31:0] len_w;

  always_comb begin
    bytes_to_bound = 13'(BOUNDARY_4K) - {1'b0, addr_lo};
    beats_to_bound = 32'(bytes_to_bound >> BeatShift);
    len_w          = 32'(BURST_LEN);
    if (32'(remaining) < len_w) begin
      len_w = 32'(remaining);
    end
    if (beats_to_bound < len_w) begin
      len_w = beats_to_bound;
    end
    len = 9'(len_w);
  end

endmodule

// File: rtl/axi_master_wr_burst.sv
// AXI4 write master draining a FIFO into memory as 4 KB-safe INCR bursts, one burst
// outstanding. Optional B-channel watchdog: define AXI_MASTER_WR_TIMEOUT_EN.
module axi_master_wr_burst
  import axi_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0]  cfg_beats,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              src_vld,
  input  logic [DW-1:0]     src_data,
  output logic              src_rdy,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [DW-1:0]     wdata,
  output logic [DW/8-1:0]   wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  localparam int unsigned BeatShift = $clog2(DW / 8);

  if (TIMEOUT == 0 || !(DW == 32 || DW == 64) || BURST_LEN == 0 || BURST_LEN > 256)
  begin : g_param_check
    $error("axi_master_wr_burst: unsupported parameter combination");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic              err_q, err_d;
  logic [8:0]        len;
  logic              last_beat;
  logic              w_fire;
  logic              resp_timeout;

  // cur_addr/remaining only move after the last beat, so len stays stable for a burst.
  axi_burst_len_calc #(
    .DW       (DW),
    .BURST_LEN(BURST_LEN),
    .CNT_W    (CNT_W)
  ) u_len_calc (
    .addr_lo  (cur_addr_q[11:0]),
    .remaining(remaining_q),
    .len      (len)
  );

  assign awaddr  = cur_addr_q;
  assign awlen   = 8'(len - 9'd1);
  assign awsize  = axi_size(DW);
  assign awburst = BURST_INCR;
  assign awvalid = (state_q == StAddr);

  assign wdata     = src_data;
  assign wstrb     = '1;
  assign wvalid    = (state_q == StData) & src_vld;
  assign src_rdy   = (state_q == StData) & wready;
  assign last_beat = ({1'b0, beat_cnt_q} == (len - 9'd1));
  assign wlast     = (state_q == StData) & last_beat;
  assign w_fire    = wvalid & wready;

  assign bready = (state_q == StResp);
  assign done   = (state_q == StFin);
  assign busy   = (state_q == StAddr) | (state_q == StData) | (state_q == StResp);
  assign err    = err_q;

`ifdef AXI_MASTER_WR_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT + 1);

  logic [ToW-1:0] to_cnt_q, to_cnt_d;

  assign resp_timeout = (state_q == StResp) & ~bvalid & (to_cnt_q == ToW'(TIMEOUT - 1));

  // Held at zero outside RESP so every response wait starts a fresh count.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == StResp && !bvalid) begin
      to_cnt_d = to_cnt_q + ToW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign resp_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          cur_addr_d  = cfg_addr;
          remaining_d = cfg_beats;
          err_d       = 1'b0;
          state_d     = (cfg_beats == '0) ? StFin : StAddr;
        end
      end
      StAddr: begin
        if (awready) begin
          beat_cnt_d = '0;
          state_d    = StData;
        end
      end
      StData: begin
        if (w_fire) begin
          if (last_beat) begin
            remaining_d = remaining_q - CNT_W'(len);
            cur_addr_d  = cur_addr_q + (ADDR_W'(len) << BeatShift);
            beat_cnt_d  = '0;
            state_d     = StResp;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      StResp: begin
        // An error response is recorded but the remaining bursts still go out.
        if (bvalid) begin
          if (bresp != RESP_OKAY) begin
            err_d = 1'b1;
          end
          state_d = (remaining_q != '0) ? StAddr : StFin;
        end else if (resp_timeout) begin
          err_d   = 1'b1;
          state_d = StFin;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_master_wr_burst.sv
// Self-checking bench for axi_master_wr_burst: transaction-level model plus directed
// transfers; the timeout case is built only with AXI_MASTER_WR_TIMEOUT_EN.
module tb_axi_master_wr_burst;

  localparam int unsigned DW        = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned BURST_LEN = 16;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned TIMEOUT   = 32;
  localparam int unsigned BYTES     = DW / 8;

  localparam int PhIdle = 0;
  localparam int PhAddr = 1;
  localparam int PhData = 2;
  localparam int PhResp = 3;
  localparam int PhFin  = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] cfg_addr;
  logic [CNT_W-1:0]  cfg_beats;
  logic              busy, done, err;
  logic              src_vld;
  logic [DW-1:0]     src_data;
  logic              src_rdy;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid, awready;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic              wlast, wvalid, wready;
  logic [1:0]        bresp;
  logic              bvalid, bready;

  axi_master_wr_burst #(
    .DW       (DW),
    .ADDR_W   (ADDR_W),
    .BURST_LEN(BURST_LEN),
    .CNT_W    (CNT_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .cfg_addr (cfg_addr),
    .cfg_beats(cfg_beats),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .src_vld  (src_vld),
    .src_data (src_data),
    .src_rdy  (src_rdy),
    .awaddr   (awaddr),
    .awlen    (awlen),
    .awsize   (awsize),
    .awburst  (awburst),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wlast    (wlast),
    .wvalid   (wvalid),
    .wready   (wready),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  typedef struct {
    logic [31:0] addr;
    int          len;
  } burst_t;

  burst_t      bursts[$];
  logic [31:0] exp_data[$];
  logic [31:0] fifo[$];
  logic [31:0] aw_addr_log[$];
  int          aw_len_log[$];
  int          wlast_log[$];

  int          ph = PhIdle;
  logic        err_m = 1'b0;
  int          cur_len, beat, xfer_beats, resp_wait;
  int          done_cnt = 0;
  int          bready_cycles = 0;
  bit          aw_hold = 0;
  logic [31:0] hold_addr;
  logic [7:0]  hold_len;
  bit          w_fire = 0, b_fire = 0;

  // Stimulus knobs shared with the responder.
  bit stall = 0, hold_b = 0;
  int bad_idx = -1, b_idx = 0;

  // Split a transfer into bursts: cap at BURST_LEN, never cross 4 KB.
  function automatic void plan(input logic [31:0] a, input int unsigned n);
    logic [31:0] addr = a;
    int unsigned rem = n, room, l;
    while (rem > 0) begin
      room = (4096 - (addr % 4096)) / BYTES;
      l = BURST_LEN;
      if (rem < l) l = rem;
      if (room < l) l = room;
      bursts.push_back('{addr: addr, len: int'(l)});
      addr = addr + l * BYTES;
      rem  = rem - l;
    end
  endfunction

  function automatic logic [63:0] log_addr(input int i);
    return (i < aw_addr_log.size()) ? 64'(aw_addr_log[i]) : 'x;
  endfunction
  function automatic logic [63:0] log_len(input int i);
    return (i < aw_len_log.size()) ? 64'(aw_len_log[i]) : 'x;
  endfunction
  function automatic logic [63:0] log_wlast(input int i);
    return (i < wlast_log.size()) ? 64'(wlast_log[i]) : 'x;
  endfunction

  // Compare process: outputs are checked every cycle on the falling edge.
  always @(negedge clk) begin
    int     ph_n;
    burst_t b;
    if (!reset_n) begin
      ph = PhIdle;
      err_m = 1'b0;
      bursts.delete();
      exp_data.delete();
      aw_hold = 0;
      w_fire = 0;
      b_fire = 0;
    end else begin
      ph_n = ph;
      chk("done", done, ph == PhFin);
      chk("busy", busy, ph == PhAddr || ph == PhData || ph == PhResp);
      chk("err", err, err_m);
      chk("awvalid", awvalid, ph == PhAddr);
      chk("wvalid", wvalid, ph == PhData && src_vld);
      chk("src_rdy", src_rdy, ph == PhData && wready);
      chk("bready", bready, ph == PhResp);
      if (done) done_cnt++;
      if (bready) bready_cycles++;
      if (aw_hold) begin
        chk("aw_stable_addr", awaddr, hold_addr);
        chk("aw_stable_len", awlen, hold_len);
      end
      aw_hold = 0;
      w_fire = src_vld && src_rdy;
      b_fire = bvalid && bready;
      case (ph)
        PhIdle: begin
          if (start) begin
            err_m = 1'b0;
            bursts.delete();
            plan(cfg_addr, cfg_beats);
            aw_addr_log.delete();
            aw_len_log.delete();
            wlast_log.delete();
            xfer_beats = 0;
            ph_n = (cfg_beats == 0) ? PhFin : PhAddr;
          end
        end
        PhAddr: begin
          if (awready) begin
            if (bursts.size() > 0) begin
              b = bursts.pop_front();
              chk("awaddr", awaddr, b.addr);
              chk("awlen", awlen, b.len - 1);
              chk("awsize", awsize, 3'd2);
              chk("awburst", awburst, 2'b01);
              aw_addr_log.push_back(awaddr);
              aw_len_log.push_back(int'(awlen));
              cur_len = b.len;
            end else begin
              chk("aw_unexpected", 1, 0);
              cur_len = 1;
            end
            beat = 0;
            ph_n = PhData;
          end else begin
            aw_hold = 1;
            hold_addr = awaddr;
            hold_len = awlen;
          end
        end
        PhData: begin
          if (src_vld && wready) begin
            if (exp_data.size() > 0) chk("wdata", wdata, exp_data.pop_front());
            else chk("w_extra_beat", 1, 0);
            chk("wstrb", wstrb, 4'hF);
            chk("wlast", wlast, beat == cur_len - 1);
            if (wlast) wlast_log.push_back(xfer_beats + 1);
            beat++;
            xfer_beats++;
            if (beat == cur_len) begin
              ph_n = PhResp;
              resp_wait = 0;
            end
          end
        end
        PhResp: begin
          if (bvalid) begin
            if (bresp != 2'b00) err_m = 1'b1;
            ph_n = (bursts.size() != 0) ? PhAddr : PhFin;
          end
`ifdef AXI_MASTER_WR_TIMEOUT_EN
          else begin
            resp_wait++;
            if (resp_wait == TIMEOUT) begin
              err_m = 1'b1;
              bursts.delete();
              ph_n = PhFin;
            end
          end
`endif
        end
        default: ph_n = PhIdle;
      endcase
      ph = ph_n;
    end
  end

  // Responder: FIFO source, AW/W ready and B channel, updated just after each rise.
  initial begin
    src_vld = 0;
    src_data = '0;
    awready = 0;
    wready = 0;
    bvalid = 0;
    bresp = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        fifo.delete();
        src_vld = 0;
        bvalid = 0;
        bresp = 2'b00;
        awready = 0;
        wready = 0;
      end else begin
        if (w_fire && fifo.size() > 0) fifo.delete(0);
        if (!(src_vld && !w_fire)) begin
          src_vld = (fifo.size() > 0) && (!stall || $urandom_range(0, 3) != 0);
        end
        src_data = (fifo.size() > 0) ? fifo[0] : '0;
        awready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        wready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (b_fire) begin
          bvalid = 0;
          b_idx++;
        end else if (!bvalid && bready && !hold_b) begin
          bvalid = !stall || ($urandom_range(0, 1) == 1);
          bresp = (b_idx == bad_idx) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  task automatic launch(input logic [31:0] addr, input int beats, output int d0);
    logic [31:0] d;
    @(posedge clk);
    #2;
    for (int i = 0; i < beats; i++) begin
      d = $urandom;
      fifo.push_back(d);
      exp_data.push_back(d);
    end
    b_idx = 0;
    cfg_addr = addr;
    cfg_beats = CNT_W'(beats);
    start = 1;
    d0 = done_cnt;
    @(posedge clk);
    #2;
    start = 0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("done_once", done_cnt - d0, 1);
  endtask

  task automatic xfer(input logic [31:0] addr, input int beats, input int budget);
    int d0;
    launch(addr, beats, d0);
    wait_done(d0, budget);
    chk("beats_moved", xfer_beats, beats);
    chk("beats_left", exp_data.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    reset_n = 0;
    start = 0;
    cfg_addr = '0;
    cfg_beats = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_src_rdy", src_rdy, 0);
    reset_n = 1;

    // Three bursts from an aligned base.
    xfer(32'h1000, 40, 400);
    chk("t1_aw_count", aw_len_log.size(), 3);
    chk("t1_len0", log_len(0), 15);
    chk("t1_len1", log_len(1), 15);
    chk("t1_len2", log_len(2), 7);
    chk("t1_addr0", log_addr(0), 32'h1000);
    chk("t1_addr1", log_addr(1), 32'h1040);
    chk("t1_addr2", log_addr(2), 32'h1080);
    chk("t1_wlast0", log_wlast(0), 16);
    chk("t1_wlast1", log_wlast(1), 32);
    chk("t1_wlast2", log_wlast(2), 40);
    chk("t1_err", err, 0);

    // Start just below a 4 KB boundary.
    xfer(32'h1FF0, 16, 400);
    chk("t2_aw_count", aw_len_log.size(), 2);
    chk("t2_len0", log_len(0), 3);
    chk("t2_addr0", log_addr(0), 32'h1FF0);
    chk("t2_len1", log_len(1), 11);
    chk("t2_addr1", log_addr(1), 32'h2000);

    // Random stalls on every channel.
    stall = 1;
    xfer(32'h3000, 64, 3000);
    stall = 0;
    chk("t3_aw_count", aw_len_log.size(), 4);

    // Error response on the second of three bursts.
    bad_idx = 1;
    xfer(32'h1000, 40, 400);
    bad_idx = -1;
    chk("t4_err", err, 1);
    chk("t4_aw_count", aw_len_log.size(), 3);
    xfer(32'h4000, 4, 200);
    chk("t4_err_cleared", err, 0);

    // Zero-length transfer: done two cycles after start, no address phase.
    @(posedge clk);
    #2;
    cfg_addr = 32'h5000;
    cfg_beats = '0;
    start = 1;
    d0 = done_cnt;
    @(negedge clk);
    chk("t5_done_early", done, 0);
    @(posedge clk);
    #2;
    start = 0;
    @(negedge clk);
    chk("t5_done", done, 1);
    chk("t5_busy", busy, 0);
    wait_done(d0, 10);
    chk("t5_no_aw", aw_len_log.size(), 0);

    // A start pulsed mid-transfer is ignored.
    launch(32'h5000, 20, d0);
    repeat (5) @(posedge clk);
    #2;
    cfg_addr = 32'h9000;
    cfg_beats = CNT_W'(3);
    start = 1;
    @(posedge clk);
    #2;
    start = 0;
    wait_done(d0, 400);
    chk("t6_aw_count", aw_len_log.size(), 2);
    chk("t6_addr1", log_addr(1), 32'h5040);
    chk("t6_beats", xfer_beats, 20);

    // Reset during the fifth data beat.
    launch(32'h6000, 16, d0);
    for (int i = 0; i < 100 && xfer_beats < 4; i++) @(posedge clk);
    #2;
    chk("t7_beats_before", xfer_beats, 4);
    chk("t7_wvalid_before", wvalid, 1);
    reset_n = 0;
    #1;
    chk("t7_awvalid", awvalid, 0);
    chk("t7_wvalid", wvalid, 0);
    chk("t7_bready", bready, 0);
    chk("t7_busy", busy, 0);
    chk("t7_src_rdy", src_rdy, 0);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1;
    xfer(32'h7000, 8, 200);
    chk("t7_aw_count", aw_len_log.size(), 1);

`ifdef AXI_MASTER_WR_TIMEOUT_EN
    // Withheld write response trips the watchdog.
    hold_b = 1;
    bready_cycles = 0;
    xfer(32'h8000, 4, 400);
    hold_b = 0;
    chk("t8_err", err, 1);
    chk("t8_resp_cycles", bready_cycles, TIMEOUT);
    xfer(32'h8100, 2, 200);
    chk("t8_err_cleared", err, 0);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_master_wr_burst.md
Name: axi_master_wr_burst

Overview:
- AXI4 write master that drains the read side of a sync FIFO and writes a programmed number of beats to memory as INCR bursts.
- Sits between an FFT result FIFO (the rd_vld/rd_rdy/rd_dout side) and the AXI interconnect.
- Splits the transfer into bursts of at most BURST_LEN beats; no burst crosses a 4 KB boundary.
- One outstanding burst at a time: AW, then all W beats, then B.

Parameters:
- DW, 32, data width in bits; legal values 32 or 64.
- ADDR_W, 32, AXI address width.
- BURST_LEN, 16, maximum beats per burst; power of two, 1..256.
- CNT_W, 16, width of the total-beat counter.
- TIMEOUT, 1024, watchdog cycles for the B channel (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; captures cfg_* when idle
- cfg_addr  in  ADDR_W  byte start address; must be aligned to DW/8
- cfg_beats  in  CNT_W  total beats to write
- busy  out  1  high from the start acceptance through final completion
- done  out  1  one-cycle pulse when the transfer completes
- err  out  1  sticky error flag; cleared on the next accepted start
- src_vld  in  1  FIFO has data
- src_data  in  DW  FIFO head data
- src_rdy  out  1  pops the FIFO
- awaddr  out  ADDR_W; awlen  out  8; awsize  out  3; awburst  out  2
- awvalid  out  1; awready  in  1
- wdata  out  DW; wstrb  out  DW/8; wlast  out  1; wvalid  out  1; wready  in  1
- bresp  in  2; bvalid  in  1; bready  out  1

Behaviour:
- Reset is asynchronous and active-low on reset_n, clocked by clk.
  - All outputs reset to 0: awvalid, wvalid, bready, busy, done, err, src_rdy.
  - State returns to IDLE; counters clear.
  - A reset mid-burst abandons the burst with no cleanup.
- FSM states: IDLE -> ADDR -> DATA -> RESP -> (ADDR or FIN) -> IDLE.
- IDLE:
  - start registers cfg_addr/cfg_beats into cur_addr/remaining, clears err, sets busy.
  - If cfg_beats == 0, go to FIN; otherwise go to ADDR.
  - start is ignored while busy.
- ADDR:
  - len = min(BURST_LEN, remaining, (4096 - cur_addr[11:0]) / (DW/8)).
  - awaddr = cur_addr, awlen = len-1.
  - awsize = 2 for DW=32, 3 for DW=64; awburst = 2'b01 (INCR).
  - awvalid rises on the cycle ADDR is entered and holds with stable payload until awready; then go to DATA.
- DATA:
  - wvalid = src_vld; src_rdy = wready; wdata = src_data (combinational pass-through, valid only in DATA).
  - wstrb = all ones.
  - wlast = 1 on the beat where beat_cnt == len-1.
  - A beat transfers when wvalid & wready.
  - Once wvalid is asserted, src_vld stays asserted until the beat is taken (FIFO guarantees this).
  - After the last beat: remaining -= len, cur_addr += len*DW/8, go to RESP.
- RESP:
  - bready = 1.
  - On bvalid: if bresp != 2'b00, set err.
  - Then go to ADDR if remaining != 0, else FIN.
  - A bad response does not abort; remaining bursts still issue.
- FIN: done = 1 for exactly one cycle, busy drops the same cycle, go to IDLE.
- Arithmetic:
  - remaining is CNT_W bits and never underflows, because len <= remaining.
  - cur_addr wraps modulo 2^ADDR_W.
- Latency: start to first awvalid is 2 cycles (IDLE capture, ADDR).
- Backpressure:
  - Stalls on awready, wready, src_vld or bvalid are unbounded unless the optional feature is enabled.
  - Stalls never drop or duplicate beats.

Optional Feature:
- Macro AXI_MASTER_WR_TIMEOUT_EN.
- When defined:
  - A counter runs in RESP and resets on entry to RESP.
  - If TIMEOUT cycles pass without bvalid, set err, drop bready and go to FIN; done still pulses.
- When undefined: RESP waits indefinitely; the counter logic is absent.

Decomposition:
- Shared package axi_pkg holds:
  - the FSM state enum;
  - AXI constants BURST_INCR = 2'b01 and RESP_OKAY = 2'b00;
  - the 4 KB boundary constant;
  - a function for awsize from DW.
- One sub-module, axi_burst_len_calc: combinational len from cur_addr, remaining and BURST_LEN. It is isolated so the boundary math gets a unit test.

Test Plan:
- cfg_addr=0x1000, cfg_beats=40, BURST_LEN=16, always ready -> three bursts.
  - awlen = 15, 15, 7.
  - awaddr = 0x1000, 0x1040, 0x1080.
  - 40 W beats carrying FIFO data in order; wlast on beats 16, 32, 40.
  - done pulses once.
- cfg_addr=0x1FF0, cfg_beats=16 -> first burst awlen=3 at 0x1FF0, then awlen=11 at 0x2000; no 4 KB crossing.
- Random wready/src_vld/awready stalls over 64 beats -> scoreboard matches exactly 64 beats in order; AW payload stable while awvalid and !awready.
- bresp=2'b10 on burst 2 of 3 -> err=1, burst 3 still issued, done pulses; the next start clears err.
- cfg_beats=0 -> no awvalid, done pulses 2 cycles after start; a start pulsed while busy is ignored.
- reset_n low during DATA beat 5 -> all valids low immediately; after release, a fresh start works. With AXI_MASTER_WR_TIMEOUT_EN and bvalid withheld, err sets after TIMEOUT cycles.
